// File: rtl/fex_issue_sched.sv
// FEX issue scheduler: reserves the single writeback slot at issue, tracks pending destinations, drives RAW stall.
// Optional macro FEX_WB_BYPASS_EN: a source retiring this cycle is forwarded instead of stalling.
module fex_issue_sched #(
  parameter int REG_IDX_W    = 5,
  parameter int MAX_LAT      = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int LAT_W        = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               iss_valid,
  output logic                               iss_ready,
  input  logic [LAT_W-1:0]                   iss_lat,
  input  logic                               iss_wr,
  input  logic [REG_IDX_W-1:0]               iss_rd,
  input  logic                               iss_int_dst,
  input  logic [REG_IDX_W-1:0]               src1,
  input  logic [REG_IDX_W-1:0]               src2,
  input  logic                               src1_used,
  input  logic                               src2_used,
  output logic                               raw_stall,
  output logic                               wb_valid,
  output logic [REG_IDX_W-1:0]               wb_rd,
  output logic                               wb_int_dst,
  output logic                               fex_busy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt
);

  localparam int NREG  = 2 ** REG_IDX_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [MAX_LAT-1:0]   slot_occ;
  logic [MAX_LAT-1:0]   slot_wr;
  logic [MAX_LAT-1:0]   slot_int;
  logic [REG_IDX_W-1:0] slot_rd [MAX_LAT];
  logic [NREG-1:0]      pend;

  logic lat_ok;
  logic slot_free;
  logic cap_ok;
  logic waw_ok;
  logic src1_byp;
  logic src2_byp;
  logic accept;

  assign wb_valid   = slot_occ[0] & slot_wr[0];
  assign wb_rd      = slot_rd[0];
  assign wb_int_dst = slot_int[0];
  assign fex_busy   = (inflight_cnt != '0);
  assign accept     = iss_valid & iss_ready;

  // Slot index MAX_LAT lies past the table, so the longest latency never collides.
  always_comb begin
    lat_ok    = (iss_lat != '0) && (iss_lat <= LAT_W'(MAX_LAT));
    slot_free = 1'b1;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (iss_lat == LAT_W'(k)) slot_free = ~slot_occ[k];
    end
    cap_ok = (inflight_cnt - CNT_W'(slot_occ[0])) < CNT_W'(MAX_INFLIGHT);
    waw_ok = ~iss_wr | ~pend[iss_rd] | (wb_valid & (wb_rd == iss_rd));
  end

`ifdef FEX_WB_BYPASS_EN
  assign src1_byp = wb_valid & (wb_rd == src1) & ~(iss_valid & iss_wr & (iss_rd == src1));
  assign src2_byp = wb_valid & (wb_rd == src2) & ~(iss_valid & iss_wr & (iss_rd == src2));
`else
  assign src1_byp = 1'b0;
  assign src2_byp = 1'b0;
`endif

  assign raw_stall = (src1_used & pend[src1] & ~src1_byp) |
                     (src2_used & pend[src2] & ~src2_byp);

  assign iss_ready = lat_ok & slot_free & cap_ok & waw_ok & ~raw_stall;

  // Shift toward slot 0 every cycle; a new op lands in slot lat-1 so it reaches slot 0 after lat cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_occ     <= '0;
      slot_wr      <= '0;
      slot_int     <= '0;
      for (int k = 0; k < MAX_LAT; k++) slot_rd[k] <= '0;
      pend         <= '0;
      inflight_cnt <= '0;
    end else begin
      slot_occ <= {1'b0, slot_occ[MAX_LAT-1:1]};
      slot_wr  <= {1'b0, slot_wr[MAX_LAT-1:1]};
      slot_int <= {1'b0, slot_int[MAX_LAT-1:1]};
      for (int k = 0; k < MAX_LAT - 1; k++) slot_rd[k] <= slot_rd[k+1];
      slot_rd[MAX_LAT-1] <= '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        if (accept && (iss_lat == LAT_W'(k + 1))) begin
          slot_occ[k] <= 1'b1;
          slot_wr[k]  <= iss_wr;
          slot_int[k] <= iss_int_dst;
          slot_rd[k]  <= iss_rd;
        end
      end
      if (wb_valid) pend[wb_rd] <= 1'b0;
      if (accept && iss_wr) pend[iss_rd] <= 1'b1;
      case ({accept, slot_occ[0]})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

endmodule

// File: doc/fex_issue_sched.md
Name: fex_issue_sched

Overview:
- Issue scheduler and writeback reservation controller for the pipelined floating-point execution unit (FEX).
- Sits beside the hazard unit in decode.
- Accepts FP ops with known fixed latency and reserves the single FEX writeback slot at issue. Tracks pending destination registers in a scoreboard and drives RAW stall, busy and writeback signals.
- Replaces the coarse "FEX busy" stall with per-register, per-cycle scheduling.

Parameters:
- REG_IDX_W, 5, register index width; the scoreboard holds 2**REG_IDX_W entries.
- MAX_LAT, 8, maximum FEX latency in cycles (legal latency range 1..MAX_LAT).
- MAX_INFLIGHT, 4, maximum concurrently issued FEX ops.
- LAT_W, 4, width of the latency field; must satisfy 2**LAT_W > MAX_LAT.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  decode presents an FP op for issue
- iss_ready  out  1  op accepted this cycle when iss_valid & iss_ready
- iss_lat  in  LAT_W  op latency in cycles
- iss_wr  in  1  op writes a register
- iss_rd  in  REG_IDX_W  destination register
- iss_int_dst  in  1  destination is the integer regfile (FP->int convert)
- src1, src2  in  REG_IDX_W  source registers of the op in decode (any type)
- src1_used, src2_used  in  1  source is actually read
- raw_stall  out  1  a used source is pending in FEX
- wb_valid  out  1  FEX result writes back this cycle
- wb_rd  out  REG_IDX_W  writeback register
- wb_int_dst  out  1  writeback targets the integer regfile
- fex_busy  out  1  at least one op in flight
- inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  ops in flight

Behaviour:
- Reservation table: slots 0..MAX_LAT-1, each holding {occ, wr, rd, int_dst}.
  - Every cycle each slot k takes the value of slot k+1; slot MAX_LAT-1 takes empty.
  - An op accepted in cycle t with latency L is written into slot L-1 at that edge.
  - It therefore reaches slot 0 in cycle t+L, retires in cycle t+L, and drives its writeback in that cycle.
- Outputs:
  - wb_valid = slot0.occ & slot0.wr; wb_rd = slot0.rd; wb_int_dst = slot0.int_dst.
  - All three come straight from slot-0 registers, so they carry no combinational path from inputs.
- Scoreboard pend[2**REG_IDX_W]:
  - Set pend[iss_rd] on an accepted op with iss_wr.
  - Clear pend[wb_rd] when wb_valid.
  - If both happen on the same register in the same cycle, the set wins.
- iss_ready is 1 only when all of the following hold:
  - iss_lat is in 1..MAX_LAT; latency 0 or above MAX_LAT is never accepted.
  - Slot iss_lat is empty (writeback-port structural check). Slot MAX_LAT is treated as always empty.
  - (inflight_cnt - slot0.occ) < MAX_INFLIGHT.
  - For iss_wr=1: no WAW, i.e. pend[iss_rd] is 0, or the pending write retires this cycle (wb_valid & wb_rd==iss_rd).
  - raw_stall is 0.
- iss_ready is independent of iss_valid.
- raw_stall = (src1_used & pend[src1]) | (src2_used & pend[src2]).
- inflight_cnt:
  - +1 on accept, -1 on slot0.occ retire; simultaneous accept and retire leaves it unchanged.
  - Never exceeds MAX_INFLIGHT.
- fex_busy = inflight_cnt != 0.
- Ops with iss_wr=0 still occupy a slot and count toward inflight_cnt. They produce no wb_valid and no scoreboard bit.
- Reset:
  - Clears all slots, pend and inflight_cnt, including mid-operation; in-flight ops are discarded.
  - Outputs during and after reset: wb_valid=0, wb_rd=0, wb_int_dst=0, fex_busy=0, inflight_cnt=0, raw_stall=0.
  - iss_ready is combinational and reflects only the inputs after reset.
- No flush input: accepted ops always complete.

Optional Feature:
- FEX_WB_BYPASS_EN
- Defined:
  - A source matching the register retiring this cycle (wb_valid & wb_rd==srcN) does not raise raw_stall, provided that register is not also being re-issued.
  - Decode forwards wb data directly.
- Undefined: raw_stall uses pend only, so the consumer issues one cycle later.

Test Plan:
- Reset, then issue lat=3 wr rd=7 at cycle 10 -> wb_valid=1, wb_rd=7 exactly at cycle 13; pend[7] clear at cycle 14; fex_busy=1 cycles 11-13; inflight_cnt 1 then 0.
- Writeback collision:
  - Issue lat=4 rd=2 at cycle 0, then lat=3 rd=3 at cycle 1 -> second op refused (iss_ready=0) because slot 3 is taken.
  - lat=2 at cycle 1 is accepted, with wb at cycle 3 and cycle 4.
- Capacity: four lat=8 ops at cycles 0-3 -> iss_ready=0 at cycle 4 for any lat; at cycle 8 a retire occurs and issue is accepted the same cycle; inflight_cnt stays 4.
- RAW/WAW:
  - After a lat=5 op writing rd=9, src1=9 with src1_used=1 -> raw_stall=1 until the wb cycle.
  - The wb cycle gives raw_stall=1 without FEX_WB_BYPASS_EN and 0 with it.
  - Re-issue to rd=9 is accepted in the wb cycle and pend[9] stays 1.
- Illegal latency: iss_lat=0 and iss_lat=9 with an empty table -> iss_ready=0 and no state change.
- Reset mid-op: issue lat=6 rd=4, assert rst at cycle 3 -> wb_valid never asserted for rd=4, pend[4]=0, fex_busy=0 from the cycle after rst.
